// File: rtl/lut_neuron_pkg.sv
// lut_neuron_pkg: shared types and helpers for the reloadable LUT neuron layer
package lut_neuron_pkg;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    function automatic int addr_w(input int fan_in, input int in_bits);
        return fan_in * in_bits;
    endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// lut_neuron_table: one neuron's writable truth table, sync read with read-before-write
module lut_neuron_table #(
    parameter int ADDR_W   = 8,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [OUT_BITS-1:0] wdata_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [OUT_BITS-1:0] rdata_o
);

    logic [OUT_BITS-1:0] mem_q [2**ADDR_W];
    logic [OUT_BITS-1:0] rdata_q;

    // table storage: plain write port, no reset (the top sweeps it clear)
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // read register doubles as the layer output register; it samples the pre-write contents
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_neuron_layer_rt.sv
// lut_neuron_layer_rt: layer of runtime-loadable LUT neurons with streaming handshake
module lut_neuron_layer_rt
    import lut_neuron_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int FAN_IN      = 4,
    parameter int IN_BITS     = 2,
    parameter int OUT_BITS    = 2,
    localparam int ADDR_W     = addr_w(FAN_IN, IN_BITS),
    localparam int NID_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_we_i,
    input  logic [NID_W-1:0]                cfg_neuron_i,
    input  logic [ADDR_W-1:0]               cfg_addr_i,
    input  logic [OUT_BITS-1:0]             cfg_data_i,
    output logic                            cfg_ready_o,
    input  logic                            s_valid_i,
    output logic                            s_ready_o,
    input  logic [NUM_NEURONS*ADDR_W-1:0]   s_data_i,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic [NUM_NEURONS*OUT_BITS-1:0] m_data_o
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic                clearing, accept;
    logic [ADDR_W-1:0]   waddr;
    logic [OUT_BITS-1:0] wdata;

    // state, sweep counter and output-valid registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            m_valid_q <= m_valid_d;
        end
    end

    // sweep ends after the all-ones entry is written; counter parks there instead of wrapping
    always_comb begin
        state_d   = (state_q == ST_CLEAR && clr_cnt_q == '1) ? ST_RUN : state_q;
        clr_cnt_d = (state_q == ST_CLEAR && clr_cnt_q != '1) ? clr_cnt_q + 1'b1 : clr_cnt_q;
        m_valid_d = accept ? 1'b1 : (m_ready_i ? 1'b0 : m_valid_q);
    end

    // handshake outputs and the shared write-port mux (sweep overrides config)
    always_comb begin
        clearing    = (state_q == ST_CLEAR);
        cfg_ready_o = !clearing;
        s_ready_o   = !clearing && (m_ready_i || !m_valid_q);
        accept      = s_valid_i && s_ready_o;
        waddr       = clearing ? clr_cnt_q : cfg_addr_i;
        wdata       = clearing ? '0 : cfg_data_i;
    end

    assign m_valid_o = m_valid_q;

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_n
        logic we;
        assign we = clearing || (cfg_we_i && 32'(cfg_neuron_i) == n);
        lut_neuron_table #(
            .ADDR_W   (ADDR_W),
            .OUT_BITS (OUT_BITS)
        ) u_table (
            .clk     (clk),
            .rst     (rst),
            .we_i    (we),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .re_i    (accept),
            .raddr_i (s_data_i[n*ADDR_W +: ADDR_W]),
            .rdata_o (m_data_o[n*OUT_BITS +: OUT_BITS])
        );
    end

endmodule
